// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared widths, response code and FSM state types for the AXI4-Lite slave.
// Contents: ADDR_W, DATA_W, RESP_OKAY, wr_state_t, rd_state_t.
package axi4_lite_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_VALID} rd_state_t;
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bus bundle with master/slave modports.
// Signals: AW (AWADDR/AWVALID/AWREADY), W (WDATA/WVALID/WREADY, WSTRB when AXI4L_SLV_WSTRB_EN),
// B (BRESP/BVALID/BREADY), AR (ARADDR/ARVALID/ARREADY), R (RDATA/RRESP/RVALID/RREADY).
interface axi4_lite_if;
    import axi4_lite_pkg::*;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
`ifdef AXI4L_SLV_WSTRB_EN
    logic [3:0]        WSTRB;
`endif
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    modport slave (
`ifdef AXI4L_SLV_WSTRB_EN
        input WSTRB,
`endif
        input AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
    modport master (
`ifdef AXI4L_SLV_WSTRB_EN
        output WSTRB,
`endif
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: 4x32 register array, one byte-enabled write port, one async read port.
// Ports: clk, rst (async, active-high), we/waddr/wdata/wbe write port, raddr/rdata read port.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wbe,
    input  logic [1:0]        raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] regs [4];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= RST_VAL;
        end else if (we) begin
            for (int b = 0; b < 4; b++) if (wbe[b]) regs[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
    assign rdata = regs[raddr];
endmodule

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite slave with four 32-bit registers, independent AW/W capture.
// Ports: ACLK, ARESET (async, active-high), bus (axi4_lite_if.slave).
// Option: AXI4L_SLV_WSTRB_EN adds byte strobes; otherwise every write covers all 32 bits.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter logic [31:0] REG_RST_VAL = 32'h0000_0000
) (
    input logic       ACLK,
    input logic       ARESET,
    axi4_lite_if.slave bus
);
    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic [ADDR_W-1:0] addr_q, wr_addr;
    logic [DATA_W-1:0] data_q, wr_data, rd_word, rdata_q;
    logic [3:0]        strb_q, w_strb, wr_be;
    logic              aw_hs, w_hs, ar_hs, we;
`ifdef AXI4L_SLV_WSTRB_EN
    assign w_strb = bus.WSTRB;
`else
    assign w_strb = 4'hF;
`endif
    // Readiness is gated by reset so nothing is offered while ARESET is high.
    assign bus.AWREADY = !ARESET && (wr_state == WR_IDLE || wr_state == WR_HAVE_DATA);
    assign bus.WREADY  = !ARESET && (wr_state == WR_IDLE || wr_state == WR_HAVE_ADDR);
    assign bus.ARREADY = !ARESET && rd_state == RD_IDLE;
    assign bus.BVALID  = wr_state == WR_RESP;
    assign bus.BRESP   = RESP_OKAY;
    assign bus.RVALID  = rd_state == RD_VALID;
    assign bus.RRESP   = RESP_OKAY;
    assign bus.RDATA   = rdata_q;
    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID && bus.WREADY;
    assign ar_hs = bus.ARVALID && bus.ARREADY;
    // The write commits at the edge where the second half arrives; each half comes
    // either from this cycle's handshake or from the latched copy.
    assign we      = (aw_hs || wr_state == WR_HAVE_ADDR) && (w_hs || wr_state == WR_HAVE_DATA);
    assign wr_addr = aw_hs ? bus.AWADDR : addr_q;
    assign wr_data = w_hs ? bus.WDATA : data_q;
    assign wr_be   = w_hs ? w_strb : strb_q;
    axi4_lite_regfile #(.RST_VAL(REG_RST_VAL)) u_regfile (
        .clk(ACLK), .rst(ARESET), .we(we), .waddr(wr_addr[3:2]), .wdata(wr_data),
        .wbe(wr_be), .raddr(bus.ARADDR[3:2]), .rdata(rd_word)
    );
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            if (aw_hs) addr_q <= bus.AWADDR;
            if (w_hs) begin
                data_q <= bus.WDATA;
                strb_q <= w_strb;
            end
            wr_state <= we ? WR_RESP :
                        aw_hs ? WR_HAVE_ADDR :
                        w_hs ? WR_HAVE_DATA :
                        (wr_state == WR_RESP && bus.BREADY) ? WR_IDLE : wr_state;
        end
    end
    // rd_word is the pre-edge register value, so a same-edge write is not visible here.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rd_state <= RD_VALID;
            rdata_q  <= rd_word;
        end else if (rd_state == RD_VALID && bus.RREADY) begin
            rd_state <= RD_IDLE;
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb_axi4_lite_slave: randomized self-checking bench for axi4_lite_slave against an array model.
module tb_axi4_lite_slave;
    localparam logic [31:0] RST = 32'h5A5A_C3C3;
`ifdef AXI4L_SLV_WSTRB_EN
    localparam bit STRB_EN = 1;
`else
    localparam bit STRB_EN = 0;
`endif
    logic clk = 0;
    logic rst = 1;
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] mdl [4];
    axi4_lite_if bus();
    axi4_lite_slave #(.REG_RST_VAL(RST)) dut (.ACLK(clk), .ARESET(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic void mdl_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b] || !STRB_EN) mdl[a[3:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 4; i++) mdl[i] = RST;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, output bit ok);
        bit aw_done, w_done, ra, rw;
        aw_done = 0; w_done = 0; ok = 0;
        bus.AWADDR = a; bus.WDATA = d;
`ifdef AXI4L_SLV_WSTRB_EN
        bus.WSTRB = s;
`endif
        for (int k = 0; k < 60 && !(aw_done && w_done); k++) begin
            if (!aw_done && k >= aw_dly) bus.AWVALID = 1;
            if (!w_done && k >= w_dly) bus.WVALID = 1;
            ra = bus.AWVALID && bus.AWREADY;
            rw = bus.WVALID && bus.WREADY;
            @(negedge clk);
            if (ra) begin bus.AWVALID = 0; aw_done = 1; end
            if (rw) begin bus.WVALID = 0; w_done = 1; end
        end
        bus.AWVALID = 0; bus.WVALID = 0;
        for (int k = 0; k < 60 && aw_done && w_done; k++) begin
            if (bus.BVALID) begin
                ok = bus.BRESP == 2'b00;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d, output bit ok);
        bit got;
        got = 0; ok = 0; d = 'x;
        bus.ARADDR = a; bus.ARVALID = 1;
        for (int k = 0; k < 60 && !got; k++) begin
            got = bus.ARREADY;
            @(negedge clk);
        end
        bus.ARVALID = 0;
        if (got && bus.RVALID && bus.RRESP == 2'b00) begin
            d = bus.RDATA; ok = 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ok;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 00000", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
        end
        n_cmp++;
        if (bus.RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.RDATA); end
        rst = 0;
        #1;
        n_cmp++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            n_fail++; $display("FAIL post_reset_ready got %b exp 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
        end
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), d, ok);
            n_cmp++;
            if (!ok || d !== RST) begin n_fail++; $display("FAIL reset_reg%0d got %h exp %h", i, d, RST); end
        end
    endtask

    task automatic test_same_cycle();
        bus.AWADDR = 4'h4; bus.WDATA = 32'hDEAD_BEEF; bus.AWVALID = 1; bus.WVALID = 1;
`ifdef AXI4L_SLV_WSTRB_EN
        bus.WSTRB = 4'hF;
`endif
        n_cmp++;
        if ({bus.AWREADY, bus.WREADY} !== 2'b11) begin n_fail++; $display("FAIL same_ready got %b exp 11", {bus.AWREADY, bus.WREADY}); end
        @(negedge clk);
        bus.AWVALID = 0; bus.WVALID = 0;
        n_cmp++;
        if ({bus.BVALID, bus.BRESP} !== 3'b100) begin n_fail++; $display("FAIL same_b got %b exp 100", {bus.BVALID, bus.BRESP}); end
        @(negedge clk);
        n_cmp++;
        if (bus.BVALID !== 1'b0) begin n_fail++; $display("FAIL same_b_clear got %b exp 0", bus.BVALID); end
        mdl_write(4'h4, 32'hDEAD_BEEF, 4'hF);
        bus.ARADDR = 4'h4; bus.ARVALID = 1;
        @(negedge clk);
        bus.ARVALID = 0;
        n_cmp++;
        if (!bus.RVALID || bus.RDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL same_read got %b/%h exp 1/deadbeef", bus.RVALID, bus.RDATA); end
        @(negedge clk);
    endtask

    task automatic test_w_first();
        logic [31:0] d;
        bit ok;
        bus.WDATA = 32'h1234_5678; bus.WVALID = 1;
`ifdef AXI4L_SLV_WSTRB_EN
        bus.WSTRB = 4'hF;
`endif
        @(negedge clk);
        bus.WVALID = 0;
        n_cmp++;
        if (bus.WREADY !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready got %b exp 0", bus.WREADY); end
        repeat (2) begin
            n_cmp++;
            if (bus.BVALID !== 1'b0) begin n_fail++; $display("FAIL wfirst_early_b got %b exp 0", bus.BVALID); end
            @(negedge clk);
        end
        bus.AWADDR = 4'hC; bus.AWVALID = 1;
        @(negedge clk);
        bus.AWVALID = 0;
        n_cmp++;
        if (bus.BVALID !== 1'b1) begin n_fail++; $display("FAIL wfirst_b got %b exp 1", bus.BVALID); end
        @(negedge clk);
        mdl_write(4'hC, 32'h1234_5678, 4'hF);
        rd(4'hC, d, ok);
        n_cmp++;
        if (!ok || d !== 32'h1234_5678) begin n_fail++; $display("FAIL wfirst_reg3 got %h exp 12345678", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, v;
        v = $urandom;
        bus.BREADY = 0;
        bus.AWADDR = 4'h8; bus.WDATA = v; bus.AWVALID = 1; bus.WVALID = 1;
`ifdef AXI4L_SLV_WSTRB_EN
        bus.WSTRB = 4'hF;
`endif
        @(negedge clk);
        bus.AWVALID = 0; bus.WVALID = 0;
        mdl_write(4'h8, v, 4'hF);
        repeat (5) begin
            n_cmp++;
            if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b100) begin
                n_fail++; $display("FAIL bp_b got %b exp 100", {bus.BVALID, bus.AWREADY, bus.WREADY});
            end
            @(negedge clk);
        end
        bus.BREADY = 1;
        @(negedge clk);
        n_cmp++;
        if (bus.BVALID !== 1'b0) begin n_fail++; $display("FAIL bp_b_clear got %b exp 0", bus.BVALID); end
        bus.RREADY = 0; bus.ARADDR = 4'h8; bus.ARVALID = 1;
        @(negedge clk);
        bus.ARVALID = 0;
        d = bus.RDATA;
        repeat (5) begin
            n_cmp++;
            if ({bus.RVALID, bus.ARREADY} !== 2'b10 || bus.RDATA !== mdl[2]) begin
                n_fail++; $display("FAIL bp_r got %b/%h exp 10/%h", {bus.RVALID, bus.ARREADY}, bus.RDATA, mdl[2]);
            end
            @(negedge clk);
        end
        bus.RREADY = 1;
        @(negedge clk);
        n_cmp++;
        if (bus.RVALID !== 1'b0 || d !== v) begin n_fail++; $display("FAIL bp_r_clear got %b/%h exp 0/%h", bus.RVALID, d, v); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        bit ok;
        wr(4'h4, 32'h1, 4'hF, 0, 0, ok);
        mdl_write(4'h4, 32'h1, 4'hF);
        bus.AWADDR = 4'h5; bus.WDATA = 32'h2; bus.AWVALID = 1; bus.WVALID = 1;
        bus.ARADDR = 4'h4; bus.ARVALID = 1;
        @(negedge clk);
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        n_cmp++;
        if (!ok || !bus.RVALID || !bus.BVALID || bus.RDATA !== 32'h1) begin
            n_fail++; $display("FAIL collide_old got %b%b%b/%h exp 111/00000001", ok, bus.RVALID, bus.BVALID, bus.RDATA);
        end
        @(negedge clk);
        mdl_write(4'h5, 32'h2, 4'hF);
        rd(4'h4, d, ok);
        n_cmp++;
        if (!ok || d !== 32'h2) begin n_fail++; $display("FAIL collide_new got %h exp 00000002", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        bus.RREADY = 0; bus.ARADDR = 4'h0; bus.ARVALID = 1;
        bus.AWADDR = 4'h4; bus.AWVALID = 1;
        @(negedge clk);
        bus.ARVALID = 0; bus.AWVALID = 0;
        n_cmp++;
        if ({bus.RVALID, bus.AWREADY, bus.WREADY} !== 3'b101) begin
            n_fail++; $display("FAIL mid_pre got %b exp 101", {bus.RVALID, bus.AWREADY, bus.WREADY});
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({bus.RVALID, bus.BVALID, bus.ARREADY} !== 3'b000) begin
            n_fail++; $display("FAIL mid_async got %b exp 000", {bus.RVALID, bus.BVALID, bus.ARREADY});
        end
        @(negedge clk);
        rst = 0; bus.RREADY = 1;
        mdl_reset();
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
                n_fail++; $display("FAIL mid_after got %b exp 011", {bus.BVALID, bus.AWREADY, bus.WREADY});
            end
        end
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), d, ok);
            n_cmp++;
            if (!ok || d !== mdl[i]) begin n_fail++; $display("FAIL mid_reg%0d got %h exp %h", i, d, mdl[i]); end
        end
    endtask

`ifdef AXI4L_SLV_WSTRB_EN
    task automatic test_wstrb();
        logic [31:0] d;
        bit ok;
        wr(4'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, ok);
        wr(4'h8, 32'h0, 4'b0101, 0, 0, ok);
        rd(4'h8, d, ok);
        n_cmp++;
        if (!ok || d !== 32'hFF00_FF00) begin n_fail++; $display("FAIL wstrb_0101 got %h exp ff00ff00", d); end
        wr(4'h8, 32'h0, 4'b0000, 0, 0, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL wstrb_zero_b got 0 exp 1"); end
        rd(4'h8, d, ok);
        n_cmp++;
        if (!ok || d !== 32'hFF00_FF00) begin n_fail++; $display("FAIL wstrb_zero got %h exp ff00ff00", d); end
        mdl[2] = 32'hFF00_FF00;
    endtask
`endif

    task automatic test_random();
        logic [31:0] d, v;
        logic [3:0] a, s;
        bit ok;
        for (int n = 0; n < 60; n++) begin
            a = 4'($urandom);
            if ($urandom_range(1) == 1) begin
                v = $urandom; s = 4'($urandom);
                wr(a, v, s, $urandom_range(3), $urandom_range(3), ok);
                mdl_write(a, v, s);
                n_cmp++;
                if (!ok) begin n_fail++; $display("FAIL rand_wr%0d got no B exp B okay", n); end
            end else begin
                rd(a, d, ok);
                n_cmp++;
                if (!ok || d !== mdl[a[3:2]]) begin n_fail++; $display("FAIL rand_rd%0d addr %h got %h exp %h", n, a, d, mdl[a[3:2]]); end
            end
        end
    endtask

    initial begin
        bus.AWADDR = 0; bus.AWVALID = 0; bus.WDATA = 0; bus.WVALID = 0; bus.BREADY = 1;
        bus.ARADDR = 0; bus.ARVALID = 0; bus.RREADY = 1;
`ifdef AXI4L_SLV_WSTRB_EN
        bus.WSTRB = 4'hF;
`endif
        mdl_reset();
        test_reset();
        test_same_cycle();
        test_w_first();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid();
`ifdef AXI4L_SLV_WSTRB_EN
        test_wstrb();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axi4_lite_slave.md
AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

Interface
REQ-001 SHALL have parameter: REG_RST_VAL, 32'h0000_0000, reset value of all four registers.
REQ-002 SHALL have ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- AWADDR  in  4  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  4  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Function
REQ-003 SHALL hold four 32-bit registers REG0..REG3; ADDR[3:2] selects the register; ADDR[1:0] is ignored.
REQ-004 SHALL accept the AW and W channels independently; a handshake is VALID&&READY sampled at a rising edge.
REQ-005 SHALL drive AWREADY=1 only while no write address is latched and BVALID=0; WREADY=1 only while no write data is latched and BVALID=0.
REQ-006 SHALL latch AWADDR / WDATA on their respective handshakes, in either order or in the same cycle.
REQ-007 SHALL update the selected register at the edge where the second of the AW/W handshakes completes, and raise BVALID with BRESP=2'b00 at that same edge.
REQ-008 SHALL hold BVALID and BRESP stable until BVALID&&BREADY, then clear BVALID and the latched halves.
REQ-009 SHALL allow a new AW/W handshake no earlier than the cycle after the B handshake.
REQ-010 SHALL run the write FSM as WR_IDLE -> (AW only) WR_HAVE_ADDR or (W only) WR_HAVE_DATA or (both) WR_RESP.
- WR_HAVE_ADDR / WR_HAVE_DATA -> WR_RESP when the missing half arrives.
- WR_RESP -> WR_IDLE on BREADY.
REQ-011 SHALL run the read FSM as RD_IDLE (ARREADY=1) -> RD_VALID on ARVALID, and RD_VALID (ARREADY=0, RVALID=1) -> RD_IDLE on RREADY.
REQ-012 SHALL register RDATA at the AR handshake edge from the pre-edge register value, with RRESP=2'b00, and hold both stable while RVALID=1.
REQ-013 SHALL return the old value when a read and a write to the same register complete at the same edge; a read accepted later returns the new value.
REQ-014 SHALL keep the read and write paths fully concurrent; neither blocks the other.
REQ-015 SHALL exhibit minimum latencies of 1 cycle from AR handshake to RVALID and 1 cycle from the last AW/W handshake to BVALID.

Reset
REQ-016 SHALL, while ARESET=1, force REG0..REG3=REG_RST_VAL, both FSMs to IDLE, and AWREADY/WREADY/ARREADY/BVALID/RVALID=0, BRESP=RRESP=0 and RDATA=0.
REQ-017 SHALL assert AWREADY, WREADY and ARREADY in the first cycle after ARESET deasserts.
REQ-018 SHALL, when reset is asserted mid-transaction, drop BVALID/RVALID asynchronously, discard latched halves, and perform no register write.

Configuration
REQ-019 SHALL, with AXI4L_SLV_WSTRB_EN defined, add input WSTRB[3:0], latch it with WDATA, and update only the bytes whose strobe bit is 1; WSTRB=4'b0000 leaves the register unchanged but still produces BVALID.
REQ-020 SHALL, without AXI4L_SLV_WSTRB_EN, have no WSTRB port and write all 32 bits on every write.

Structure
REQ-021 SHALL take from package axi4_lite_pkg: ADDR_W=4, DATA_W=32, RESP_OKAY=2'b00, and the write/read state enums.
REQ-022 SHALL instantiate the register array as sub-module axi4_lite_regfile: 4x32, one write port with byte enables, one read port, async reset.

Verification
REQ-023 SHALL cover a same-cycle write: AWADDR=4'h4, WDATA=32'hDEAD_BEEF, BREADY=1 -> BVALID one cycle later with BRESP=0; a read of 4'h4 -> RDATA=32'hDEAD_BEEF one cycle after AR.
REQ-024 SHALL cover a W-first write: WVALID three cycles before AWVALID (AWADDR=4'hC, WDATA=32'h1234_5678) -> WREADY low after the W handshake, BVALID only after AW, REG3=32'h1234_5678.
REQ-025 SHALL cover backpressure: BREADY=0 for 5 cycles -> BVALID held and AWREADY=WREADY=0 throughout; RREADY=0 for 5 cycles -> RDATA stable and ARREADY=0.
REQ-026 SHALL cover a same-edge collision: REG1=32'h1 and a write of 32'h2 to 4'h5 completing on the AR edge for 4'h4 -> RDATA=32'h1; the next read -> 32'h2.
REQ-027 SHALL cover reset mid-operation: ARESET pulse while RVALID=1 and an AW is latched -> RVALID=0 immediately, all registers=REG_RST_VAL, no BVALID after release.
REQ-028 SHALL cover, with AXI4L_SLV_WSTRB_EN, REG2=32'hFFFF_FFFF, WDATA=0, WSTRB=4'b0101 -> REG2=32'hFF00_FF00.
